mem_io_responder: RTL and testbench
===================================

Name: mem_io_responder

Overview:
Target end of the CPU's byte-wide memory bus (mem_a / mem_dout / mem_din / mem_wr); it answers every access the CPU's RAM controller issues. It holds the 128KB main RAM and decodes the I/O window at mem_a[17:16]==2'b11: UART rx byte, UART tx byte via a TX FIFO, cycle counter and program stop. It drives io_buffer_full back to the CPU and sits beside cpu in the top level.

Parameters:
ADDR_WIDTH, 17, RAM byte-address width (2^17 = 128KB)
TX_DEPTH, 8, TX FIFO entries (power of two, >=4)
TX_AW, 3, log2(TX_DEPTH)

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, asynchronous, active-low
mem_a  input  32  byte address from CPU (bits 17:0 decoded)
mem_dout  input  8  write data from CPU
mem_wr  input  1  1 = write, 0 = read
mem_din  output  8  read data to CPU, registered
io_buffer_full  output  1  TX FIFO near-full flag to CPU
tx_data  output  8  FIFO head byte to UART transmitter
tx_valid  output  1  FIFO non-empty
tx_ready  input  1  UART accepts tx_data this cycle
rx_data  input  8  received UART byte
rx_valid  input  1  rx_data holds an unread byte
rx_ack  output  1  one-cycle pop of the rx byte
prog_stop  output  1  sticky: program end reached and '\0' queued
tx_overflow  output  1  sticky: a tx byte was dropped because the FIFO was full

Behaviour:
- Reset (rst_in low, async):
  - mem_din=0, rx_ack=0, prog_stop=0, tx_overflow=0, io_buffer_full=0.
  - FIFO empty, so tx_valid=0. cycle counter=0, snapshot=0, stop_pending=0.
  - RAM contents are not reset.
- Decode: io = (mem_a[17:16]==2'b11). Otherwise the access is RAM at mem_a[ADDR_WIDTH-1:0].
- RAM write (mem_wr=1, !io): ram[addr] <= mem_dout at the clock edge. No wait states.
- Reads (mem_wr=0): mem_din is loaded at the edge and is valid the cycle after the address (latency 1). mem_din holds its value during write cycles.
  - RAM: ram[addr]. A read issued the cycle after a write to the same address returns the new byte.
  - 0x30000: rx_data if rx_valid, else 0x00. rx_ack pulses high for exactly the edge-following cycle only when rx_valid=1.
  - 0x30004: returns counter[7:0] and loads snapshot <= counter.
  - 0x30005..0x30007: return snapshot bytes 1..3, so a 4-byte read is coherent.
  - Any other io address: 0x00.
- Cycle counter: 32-bit, increments every cycle after reset release, wraps 0xFFFFFFFF -> 0.
- TX writes to 0x30000:
  - mem_dout==0x00 is ignored.
  - Nonzero byte is pushed if count<TX_DEPTH, or if count==TX_DEPTH and a pop occurs in the same cycle.
  - Otherwise the byte is dropped and tx_overflow is set.
  - Writes after prog_stop=1 are ignored.
- Stop write to 0x30004 (any data): sets stop_pending.
  - While stop_pending, a 0x00 byte is pushed on the first cycle the push rule allows, with priority over any CPU tx write in that cycle; that CPU byte is dropped and flagged.
  - On that push, stop_pending clears and prog_stop goes to 1 (visible the next cycle).
  - Repeated stop writes have no further effect.
- Other io writes: ignored.
- FIFO:
  - tx_valid = (count!=0). Pop when tx_valid & tx_ready.
  - Simultaneous push and pop leaves count unchanged. Pointers wrap modulo TX_DEPTH.
  - tx_data is the head entry, stable while tx_valid & !tx_ready.
- io_buffer_full: registered, =1 when next count >= TX_DEPTH-1. The one-slot margin covers the CPU's sampling latency.
- rx: at most one rx_ack per read. Back-to-back reads of 0x30000 pop successive bytes only if rx_valid is high each cycle.

Test Plan:
- RAM: write 0xA5 to 0x00010, read 0x00010 next cycle -> mem_din=0xA5 one cycle after the read; read 0x1FFFF after writing 0x3C there -> 0x3C.
- TX: with tx_ready=0, write 'H','i',0x00 to 0x30000 -> count=2, tx_valid=1, tx_data=0x48. Then raise tx_ready -> 0x48 then 0x69 emitted, tx_valid falls after 2 pops.
- Full: tx_ready=0, write 8 nonzero bytes -> io_buffer_full=1 after the 7th push. 9th write -> dropped, tx_overflow=1, count=8. 9th write with tx_ready=1 in the same cycle -> accepted, count stays 8.
- Counter: hold counter near 0x000000FF, read 0x30004..0x30007 over 4 cycles -> bytes come from one snapshot (0xFF,0x00,0x00,0x00), not a torn value. Run 2^32 cycles (forced) -> wraps to 0.
- RX: rx_valid=1, rx_data=0x31, read 0x30000 -> mem_din=0x31, rx_ack high 1 cycle. With rx_valid=0 -> mem_din=0x00, no rx_ack.
- Stop and reset:
  - Stop write with FIFO full -> prog_stop stays 0 until a pop, then 0x00 is queued and prog_stop=1.
  - A later 0x30000 write is ignored.
  - rst_in low mid-transfer -> all outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mem_io_responder.sv
// mem_io_responder: CPU byte-bus target for the 128KB main RAM and the I/O window at 0x3xxxx (UART rx/tx, cycle counter, stop).
// Latency: reads return on mem_din one cycle after the address; writes take effect at the clock edge.
// Backpressure: none on the CPU bus; TX fullness is reported on io_buffer_full, bytes that find no room are dropped and flagged.
//
// Ports: clk_in/rst_in clock and async active-low reset; mem_a/mem_dout/mem_wr/mem_din CPU bus;
//        io_buffer_full TX near-full flag; tx_data/tx_valid/tx_ready UART TX handshake;
//        rx_data/rx_valid/rx_ack UART RX byte and pop; prog_stop/tx_overflow sticky status.

// fifo: generic single-clock FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
// Latency: a pushed entry appears on out_dat the cycle after the push.
// Backpressure: in_rdy low while full and not popping; out_vld high whenever non-empty.
module fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic         core_clk,
  input  logic         arst_n,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat,
  output logic [AW:0]  count_nxt
);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [W-1:0]  store [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;

  assign out_vld   = (count_q != '0);
  assign out_dat   = store[rd_ptr_q];
  assign count_nxt = count_d;

  always_comb begin
    pop      = out_vld & out_rdy;
    // When full, the slot freed by a same-cycle pop is reused: wr_ptr equals rd_ptr then.
    in_rdy   = (count_q < CNT_MAX) | pop;
    push     = in_vld & in_rdy;
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!push && pop) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge core_clk) begin
    if (push) begin
      store[wr_ptr_q] <= in_dat;
    end
  end

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

module mem_io_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int TX_DEPTH   = 8,
  parameter int TX_AW      = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ack,
  output logic        prog_stop,
  output logic        tx_overflow
);
  localparam logic [15:0]      OFF_UART  = 16'h0000;
  localparam logic [15:0]      OFF_CNT   = 16'h0004;
  localparam logic [TX_AW:0]   FULL_MARK = (TX_AW+1)'(TX_DEPTH - 1);

  logic [7:0]            ram [2**ADDR_WIDTH];
  logic                  io_sel;
  logic [15:0]           io_off;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  unused_addr;

  logic [7:0]  mem_din_q, mem_din_d;
  logic        rx_ack_q, rx_ack_d;
  logic [31:0] counter_q, counter_d;
  logic [31:0] snapshot_q, snapshot_d;
  logic        stop_pending_q, stop_pending_d;
  logic        prog_stop_q, prog_stop_d;
  logic        tx_overflow_q, tx_overflow_d;
  logic        io_buffer_full_q, io_buffer_full_d;

  logic           tx_wr, stop_wr, push_stop, push_cpu;
  logic           fifo_in_vld, fifo_in_rdy;
  logic [7:0]     fifo_in_dat;
  logic [TX_AW:0] fifo_count_nxt;

  assign io_sel      = (mem_a[17:16] == 2'b11);
  assign io_off      = mem_a[15:0];
  assign ram_addr    = mem_a[ADDR_WIDTH-1:0];
  assign unused_addr = ^mem_a[31:18];

  always_ff @(posedge clk_in) begin
    if (mem_wr && !io_sel) begin
      ram[ram_addr] <= mem_dout;
    end
  end

  always_comb begin
    mem_din_d  = mem_din_q;
    rx_ack_d   = 1'b0;
    snapshot_d = snapshot_q;
    counter_d  = counter_q + 32'd1;
    if (!mem_wr) begin
      if (!io_sel) begin
        mem_din_d = ram[ram_addr];
      end else begin
        case (io_off)
          OFF_UART: begin
            mem_din_d = rx_valid ? rx_data : 8'h00;
            rx_ack_d  = rx_valid;
          end
          // Reading byte 0 freezes the whole counter so bytes 1..3 match it.
          OFF_CNT: begin
            mem_din_d  = counter_q[7:0];
            snapshot_d = counter_q;
          end
          16'h0005: mem_din_d = snapshot_q[15:8];
          16'h0006: mem_din_d = snapshot_q[23:16];
          16'h0007: mem_din_d = snapshot_q[31:24];
          default:  mem_din_d = 8'h00;
        endcase
      end
    end

    tx_wr   = mem_wr & io_sel & (io_off == OFF_UART) & (mem_dout != 8'h00) & ~prog_stop_q;
    stop_wr = mem_wr & io_sel & (io_off == OFF_CNT) & ~prog_stop_q;
    // The terminating 0x00 wins the FIFO slot; any CPU byte in a stop-pending cycle is lost.
    push_stop   = stop_pending_q & fifo_in_rdy;
    push_cpu    = tx_wr & ~stop_pending_q & fifo_in_rdy;
    fifo_in_vld = push_stop | push_cpu;
    fifo_in_dat = push_stop ? 8'h00 : mem_dout;

    tx_overflow_d    = tx_overflow_q | (tx_wr & ~push_cpu);
    stop_pending_d   = (stop_pending_q & ~push_stop) | (stop_wr & ~stop_pending_q);
    prog_stop_d      = prog_stop_q | push_stop;
    // One slot of margin: the CPU may issue one more write before it sees this flag.
    io_buffer_full_d = (fifo_count_nxt >= FULL_MARK);
  end

  fifo #(
    .W     (8),
    .DEPTH (TX_DEPTH),
    .AW    (TX_AW)
  ) u_tx_fifo (
    .core_clk  (clk_in),
    .arst_n    (rst_in),
    .in_vld    (fifo_in_vld),
    .in_rdy    (fifo_in_rdy),
    .in_dat    (fifo_in_dat),
    .out_vld   (tx_valid),
    .out_rdy   (tx_ready),
    .out_dat   (tx_data),
    .count_nxt (fifo_count_nxt)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mem_din_q        <= 8'h00;
      rx_ack_q         <= 1'b0;
      counter_q        <= 32'd0;
      snapshot_q       <= 32'd0;
      stop_pending_q   <= 1'b0;
      prog_stop_q      <= 1'b0;
      tx_overflow_q    <= 1'b0;
      io_buffer_full_q <= 1'b0;
    end else begin
      mem_din_q        <= mem_din_d;
      rx_ack_q         <= rx_ack_d;
      counter_q        <= counter_d;
      snapshot_q       <= snapshot_d;
      stop_pending_q   <= stop_pending_d;
      prog_stop_q      <= prog_stop_d;
      tx_overflow_q    <= tx_overflow_d;
      io_buffer_full_q <= io_buffer_full_d;
    end
  end

  assign mem_din        = mem_din_q;
  assign rx_ack         = rx_ack_q;
  assign prog_stop      = prog_stop_q;
  assign tx_overflow    = tx_overflow_q;
  assign io_buffer_full = io_buffer_full_q;
endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: directed and random bus traffic against a queue-based reference model.
// Latency: expectations are tagged with the clock edge they describe and checked after it.
// Backpressure: tx_ready is driven by the bench; emitted bytes are matched against a queue.
module tb_mem_io_responder;
  localparam int TX_DEPTH = 8;
  localparam logic [31:0] IDLE_A = 32'h0003_0008;

  logic        clk_in, rst_in;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout, mem_din, tx_data, rx_data;
  logic        mem_wr, io_buffer_full, tx_valid, tx_ready, rx_valid, rx_ack, prog_stop, tx_overflow;

  mem_io_responder #(.ADDR_WIDTH(17), .TX_DEPTH(TX_DEPTH), .TX_AW(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
    .mem_din(mem_din), .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .prog_stop(prog_stop), .tx_overflow(tx_overflow)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    int         edge_no;
    logic [7:0] din;
    logic       ack, full, valid, stop, ovf;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] exp_tx[$];
  int         checks = 0;
  int         errors = 0;
  int         edge_cnt = 0;
  int         rst_edge = 0;

  // Reference model state
  logic [7:0]  ram_m [logic [16:0]];
  logic [16:0] ram_keys[$];
  logic [7:0]  m_fifo[$];
  logic [7:0]  m_din;
  logic [31:0] m_snap;
  logic        m_pend, m_stop, m_ovf;

  always @(posedge clk_in) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete(); exp_tx.delete(); m_fifo.delete();
    m_din = 8'h00; m_snap = 32'd0; m_pend = 1'b0; m_stop = 1'b0; m_ovf = 1'b0;
  endtask

  // One bus cycle: drive inputs after an edge and record what the next edge must produce.
  task automatic cycle(input logic wr, input logic [31:0] a, input logic [7:0] d,
                       input logic txr, input logic rxv, input logic [7:0] rxd);
    exp_t        it;
    logic        io, pop, room, tx_req, pend_old;
    logic [15:0] off;
    logic [31:0] cnt;
    @(posedge clk_in); #1;
    mem_wr = wr; mem_a = a; mem_dout = d; tx_ready = txr; rx_valid = rxv; rx_data = rxd;
    io = (a[17:16] == 2'b11);
    off = a[15:0];
    it.ack = 1'b0; tx_req = 1'b0; pend_old = m_pend;
    if (!wr) begin
      if (!io) m_din = ram_m.exists(a[16:0]) ? ram_m[a[16:0]] : 8'h00;
      else begin
        case (off)
          16'h0000: begin m_din = rxv ? rxd : 8'h00; it.ack = rxv; end
          16'h0004: begin cnt = edge_cnt - rst_edge; m_din = cnt[7:0]; m_snap = cnt; end
          16'h0005: m_din = m_snap[15:8];
          16'h0006: m_din = m_snap[23:16];
          16'h0007: m_din = m_snap[31:24];
          default:  m_din = 8'h00;
        endcase
      end
    end else if (!io) begin
      ram_m[a[16:0]] = d;
      ram_keys.push_back(a[16:0]);
    end else if (off == 16'h0000) begin
      tx_req = (d != 8'h00) && !m_stop;
    end else if (off == 16'h0004 && !m_stop) begin
      m_pend = 1'b1;
    end
    pop  = (m_fifo.size() > 0) && txr;
    room = (m_fifo.size() < TX_DEPTH) || pop;
    if (pop) exp_tx.push_back(m_fifo.pop_front());
    if (pend_old && room) begin
      m_fifo.push_back(8'h00); m_pend = 1'b0; m_stop = 1'b1;
    end
    if (tx_req) begin
      if (room && !pend_old) m_fifo.push_back(d);
      else m_ovf = 1'b1;
    end
    it.edge_no = edge_cnt + 1;
    it.din   = m_din;
    it.full  = (m_fifo.size() >= TX_DEPTH - 1);
    it.valid = (m_fifo.size() > 0);
    it.stop  = m_stop;
    it.ovf   = m_ovf;
    exp_q.push_back(it);
  endtask

  task automatic idle(input int n, input logic txr);
    for (int i = 0; i < n; i++) cycle(1'b0, IDLE_A, 8'h00, txr, 1'b0, 8'h00);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_din"}, mem_din, 0);
    chk({tag, "_rx_ack"}, rx_ack, 0);
    chk({tag, "_prog_stop"}, prog_stop, 0);
    chk({tag, "_tx_overflow"}, tx_overflow, 0);
    chk({tag, "_io_buffer_full"}, io_buffer_full, 0);
    chk({tag, "_tx_valid"}, tx_valid, 0);
  endtask

  // Monitor: compares per-edge expectations once their edge has passed, and every emitted tx byte.
  always @(negedge clk_in) begin
    exp_t it;
    while (exp_q.size() > 0 && exp_q[0].edge_no <= edge_cnt) begin
      it = exp_q.pop_front();
      chk("mem_din", mem_din, it.din);
      chk("rx_ack", rx_ack, it.ack);
      chk("io_buffer_full", io_buffer_full, it.full);
      chk("tx_valid", tx_valid, it.valid);
      chk("prog_stop", prog_stop, it.stop);
      chk("tx_overflow", tx_overflow, it.ovf);
    end
    if (rst_in === 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
      if (exp_tx.size() == 0) chk("tx_unexpected_pop", 1, 0);
      else chk("tx_data", tx_data, exp_tx.pop_front());
    end
  end

  initial begin
    logic [31:0] a;
    logic [7:0]  d;
    int          r;
    rst_in = 1'b0; mem_a = IDLE_A; mem_dout = 8'h00; mem_wr = 1'b0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    check_reset_outputs("reset");
    rst_in = 1'b1; rst_edge = edge_cnt;

    // Counter snapshot: byte 0 read at counter 0xFF, bytes 1..3 after the counter has moved on.
    while (edge_cnt + 1 - rst_edge < 255) idle(1, 1'b0);
    for (int k = 4; k < 8; k++) cycle(1'b0, 32'h0003_0000 + k, 8'h00, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 32'h0003_0004, 8'h00, 1'b0, 1'b0, 8'h00);

    // RAM write then read-back, including the top address.
    cycle(1'b1, 32'h0000_0010, 8'hA5, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 32'h0000_0010, 8'h00, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 32'h0001_FFFF, 8'h3C, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 32'h0001_FFFF, 8'h00, 1'b0, 1'b0, 8'h00);

    // RX with and without a byte waiting.
    cycle(1'b0, 32'h0003_0000, 8'h00, 1'b0, 1'b1, 8'h31);
    cycle(1'b0, 32'h0003_0000, 8'h00, 1'b0, 1'b0, 8'h77);
    idle(2, 1'b0);

    // TX: 'H','i' queued, 0x00 ignored, then drained.
    cycle(1'b1, 32'h0003_0000, 8'h48, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 32'h0003_0000, 8'h69, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 32'h0003_0000, 8'h00, 1'b0, 1'b0, 8'h00);
    idle(2, 1'b0);
    idle(4, 1'b1);

    // Fill, overflow, then push-with-pop while full.
    for (int i = 0; i < TX_DEPTH; i++) cycle(1'b1, 32'h0003_0000, 8'h41 + 8'(i), 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 32'h0003_0000, 8'h50, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 32'h0003_0000, 8'h51, 1'b1, 1'b0, 8'h00);
    idle(TX_DEPTH + 3, 1'b1);

    // Stop with a full FIFO: waits for a pop, then later tx writes are ignored.
    for (int i = 0; i < TX_DEPTH; i++) cycle(1'b1, 32'h0003_0000, 8'h61 + 8'(i), 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 32'h0003_0004, 8'h12, 1'b0, 1'b0, 8'h00);
    idle(3, 1'b0);
    idle(1, 1'b1);
    cycle(1'b1, 32'h0003_0004, 8'h00, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 32'h0003_0000, 8'h58, 1'b0, 1'b0, 8'h00);
    idle(2, 1'b1);

    // Asynchronous reset in the middle of a transfer, between clock edges.
    @(negedge clk_in);
    #2;
    rst_in = 1'b0; mem_wr = 1'b0; mem_a = IDLE_A; tx_ready = 1'b0; rx_valid = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("async_reset");
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b1; rst_edge = edge_cnt;

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 20) begin
        a = $urandom;
        if (a[17:16] == 2'b11) a[17] = 1'b0;
        cycle(1'b1, a, 8'($urandom), $urandom_range(0, 2) == 0, 1'b0, 8'h00);
      end else if (r < 40 && ram_keys.size() > 0) begin
        a = {15'd0, ram_keys[$urandom_range(0, ram_keys.size() - 1)]};
        cycle(1'b0, a, 8'h00, $urandom_range(0, 2) == 0, 1'b0, 8'h00);
      end else if (r < 65) begin
        d = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        cycle(1'b1, 32'h0003_0000, d, $urandom_range(0, 2) == 0, 1'b0, 8'h00);
      end else if (r < 80) begin
        cycle(1'b0, 32'h0003_0000, 8'h00, $urandom_range(0, 2) == 0, 1'($urandom), 8'($urandom));
      end else if (r < 92) begin
        cycle(1'b0, 32'h0003_0004 + $urandom_range(0, 3), 8'h00, $urandom_range(0, 2) == 0, 1'b0, 8'h00);
      end else if (r < 98) begin
        a = 32'h0003_0000 + $urandom_range(8, 16'hFFFF);
        cycle(1'($urandom), a, 8'($urandom), $urandom_range(0, 2) == 0, 1'b0, 8'h00);
      end else begin
        idle(1, 1'($urandom));
      end
    end

    // Final stop and drain.
    cycle(1'b1, 32'h0003_0004, 8'hFF, 1'b1, 1'b0, 8'h00);
    idle(TX_DEPTH + 4, 1'b1);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    #1;
    chk("prog_stop_final", prog_stop, 1);
    chk("tx_queue_drained", exp_tx.size(), 0);
    chk("expectations_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
